// File: rtl/flag_shadow_ctrl.sv
// C/Z/I flag owner with interrupt-entry save and RETI restore; optional nesting via FLAG_SHADOW_NEST_EN.
// Latency: INT_TAKE one cycle after the qualifying boundary; RETI restore selects shadow same cycle, flags valid next.
// Backpressure: requests at full shadow depth are held off (re-evaluated each boundary), never dropped.
module flag_shadow_ctrl #(
    parameter int SHAD_DEPTH = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic C_IN,
    input  logic Z_IN,
    input  logic FLG_C_LD,
    input  logic FLG_Z_LD,
    input  logic FLG_C_SET,
    input  logic FLG_C_CLR,
    input  logic I_SET,
    input  logic I_CLR,
    input  logic INSTR_BOUND,
    input  logic INT_REQ,
    input  logic RETI,
    output logic C_FLAG,
    output logic Z_FLAG,
    output logic I_FLAG,
    output logic INT_TAKE,
    output logic FLG_LD_SEL,
    output logic ERR
);

`ifdef FLAG_SHADOW_NEST_EN
    localparam int CAP = SHAD_DEPTH;
    localparam int AW  = $clog2(SHAD_DEPTH);
`else
    // Single shadow register; SHAD_DEPTH has no effect in this build.
    localparam int CAP = (SHAD_DEPTH > 0) ? 1 : 1;
`endif
    localparam int DW = $clog2(CAP + 1);

    typedef enum logic [1:0] {IDLE, ENTER, ISR} state_t;

    state_t        state;
    logic [DW-1:0] depth;
    logic          c_q, z_q, i_q;
    logic          int_take_q, err_q;
    logic          c_nxt, z_nxt;
    logic [1:0]    pop_val;
    logic          have_shadow, take, restore;

    assign have_shadow = (depth != '0);
    assign restore     = RETI & have_shadow;
    assign take        = INT_REQ & i_q & INSTR_BOUND & ~RETI
                         & (depth < DW'(CAP)) & (state != ENTER);

    // Next flag values; also what gets saved on a take so the boundary instruction's result survives.
    always_comb begin
        c_nxt = c_q;
        z_nxt = z_q;
        if (restore) begin
            {c_nxt, z_nxt} = pop_val;
        end else if (state != ENTER && !RETI) begin
            if (FLG_C_CLR)      c_nxt = 1'b0;
            else if (FLG_C_SET) c_nxt = 1'b1;
            else if (FLG_C_LD)  c_nxt = C_IN;
            if (FLG_Z_LD)       z_nxt = Z_IN;
        end
    end

`ifdef FLAG_SHADOW_NEST_EN
    logic [1:0] shadow [SHAD_DEPTH];

    assign pop_val = shadow[AW'(depth - DW'(1))];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < SHAD_DEPTH; k++) shadow[k] <= 2'b00;
        end else if (take) begin
            shadow[AW'(depth)] <= {c_nxt, z_nxt};
        end
    end
`else
    logic [1:0] shadow_q;

    assign pop_val = shadow_q;

    always_ff @(posedge CLK) begin
        if (RST)       shadow_q <= 2'b00;
        else if (take) shadow_q <= {c_nxt, z_nxt};
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            depth      <= '0;
            c_q        <= 1'b0;
            z_q        <= 1'b0;
            i_q        <= 1'b0;
            int_take_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            c_q        <= c_nxt;
            z_q        <= z_nxt;
            int_take_q <= take;
            err_q      <= RETI & ~have_shadow;
            if (take) begin
                i_q   <= 1'b0;
                depth <= depth + DW'(1);
                state <= ENTER;
            end else if (restore) begin
                i_q   <= 1'b1;
                depth <= depth - DW'(1);
                state <= (depth == DW'(1)) ? IDLE : ISR;
            end else begin
                if (state == ENTER) state <= ISR;
                if (!RETI) begin
                    if (I_CLR)                        i_q <= 1'b0;
                    else if (I_SET && state != ENTER) i_q <= 1'b1;
                end
            end
        end
    end

    assign C_FLAG     = c_q;
    assign Z_FLAG     = z_q;
    assign I_FLAG     = i_q;
    assign INT_TAKE   = int_take_q;
    assign ERR        = err_q;
    assign FLG_LD_SEL = restore;

endmodule

// File: tb/tb_flag_shadow_ctrl.sv
// Directed bench for flag_shadow_ctrl; nesting scenario selected by FLAG_SHADOW_NEST_EN.
module tb_flag_shadow_ctrl;
    logic CLK = 1'b0;
    logic RST, C_IN, Z_IN, FLG_C_LD, FLG_Z_LD, FLG_C_SET, FLG_C_CLR;
    logic I_SET, I_CLR, INSTR_BOUND, INT_REQ, RETI;
    logic C_FLAG, Z_FLAG, I_FLAG, INT_TAKE, FLG_LD_SEL, ERR;

    int n_assert = 0;
    int n_fail   = 0;

    flag_shadow_ctrl #(.SHAD_DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .C_IN(C_IN), .Z_IN(Z_IN),
        .FLG_C_LD(FLG_C_LD), .FLG_Z_LD(FLG_Z_LD),
        .FLG_C_SET(FLG_C_SET), .FLG_C_CLR(FLG_C_CLR),
        .I_SET(I_SET), .I_CLR(I_CLR), .INSTR_BOUND(INSTR_BOUND),
        .INT_REQ(INT_REQ), .RETI(RETI),
        .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG), .I_FLAG(I_FLAG),
        .INT_TAKE(INT_TAKE), .FLG_LD_SEL(FLG_LD_SEL), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic clr_inputs();
        RST = 0; C_IN = 0; Z_IN = 0; FLG_C_LD = 0; FLG_Z_LD = 0;
        FLG_C_SET = 0; FLG_C_CLR = 0; I_SET = 0; I_CLR = 0;
        INSTR_BOUND = 0; INT_REQ = 0; RETI = 0;
    endtask

    task automatic load_cz(input logic c, input logic z);
        C_IN = c; Z_IN = z; FLG_C_LD = 1; FLG_Z_LD = 1;
        tick();
        FLG_C_LD = 0; FLG_Z_LD = 0;
    endtask

`ifdef FLAG_SHADOW_NEST_EN
    logic [1:0] pat [4];
    logic [1:0] pop_exp [4];
`endif

    initial begin
        // 1: reset with every input high
        RST = 1; C_IN = 1; Z_IN = 1; FLG_C_LD = 1; FLG_Z_LD = 1; FLG_C_SET = 1;
        FLG_C_CLR = 1; I_SET = 1; I_CLR = 1; INSTR_BOUND = 1; INT_REQ = 1; RETI = 1;
        #2;
        tick();
        chk("rst_c", C_FLAG, 1'b0);
        chk("rst_z", Z_FLAG, 1'b0);
        chk("rst_i", I_FLAG, 1'b0);
        chk("rst_take", INT_TAKE, 1'b0);
        chk("rst_err", ERR, 1'b0);
        chk("rst_ldsel", FLG_LD_SEL, 1'b0);
        clr_inputs();
        tick();

        // 2: take, ISR modifies flags, RETI restores
        FLG_C_SET = 1; I_SET = 1;
        tick();
        FLG_C_SET = 0; I_SET = 0;
        chk("pre_c", C_FLAG, 1'b1);
        chk("pre_i", I_FLAG, 1'b1);
        INT_REQ = 1; INSTR_BOUND = 1;
        tick();
        INT_REQ = 0; INSTR_BOUND = 0;
        chk("take_pulse", INT_TAKE, 1'b1);
        chk("take_i_masked", I_FLAG, 1'b0);
        FLG_C_CLR = 1;
        tick();
        FLG_C_CLR = 0;
        chk("enter_clr_ignored", C_FLAG, 1'b1);
        chk("take_one_cycle", INT_TAKE, 1'b0);
        load_cz(1'b0, 1'b1);
        #1;
        chk("isr_c", C_FLAG, 1'b0);
        chk("isr_z", Z_FLAG, 1'b1);
        RETI = 1; FLG_C_LD = 1; C_IN = 0;
        #1;
        chk("reti_ldsel", FLG_LD_SEL, 1'b1);
        tick();
        RETI = 0; FLG_C_LD = 0;
        chk("reti_c", C_FLAG, 1'b1);
        chk("reti_z", Z_FLAG, 1'b0);
        chk("reti_i", I_FLAG, 1'b1);

        // 3: C priority and I_SET/I_CLR conflict
        FLG_C_SET = 1; FLG_C_CLR = 1; FLG_C_LD = 1; C_IN = 1;
        tick();
        FLG_C_SET = 0; FLG_C_CLR = 0; FLG_C_LD = 0;
        chk("c_clr_wins", C_FLAG, 1'b0);
        I_SET = 1; I_CLR = 1;
        tick();
        I_SET = 0; I_CLR = 0;
        chk("i_clr_wins", I_FLAG, 1'b0);

        // 4: RETI with empty shadow
        load_cz(1'b1, 1'b1);
        RETI = 1;
        #1;
        chk("err_ldsel", FLG_LD_SEL, 1'b0);
        tick();
        RETI = 0;
        chk("err_pulse", ERR, 1'b1);
        chk("err_c_hold", C_FLAG, 1'b1);
        chk("err_z_hold", Z_FLAG, 1'b1);
        tick();
        chk("err_one_cycle", ERR, 1'b0);

`ifdef FLAG_SHADOW_NEST_EN
        // 5: four nested takes, fifth held until first RETI, LIFO restore
        pat[0] = 2'b10; pat[1] = 2'b01; pat[2] = 2'b11; pat[3] = 2'b00;
        pop_exp[0] = 2'b00; pop_exp[1] = 2'b11; pop_exp[2] = 2'b01; pop_exp[3] = 2'b10;
        I_SET = 1;
        tick();
        I_SET = 0;
        for (int k = 0; k < 4; k++) begin
            load_cz(pat[k][1], pat[k][0]);
            INT_REQ = 1; INSTR_BOUND = 1;
            tick();
            INSTR_BOUND = 0;
            chk("nest_take", INT_TAKE, 1'b1);
            tick();
            I_SET = 1;
            tick();
            I_SET = 0;
        end
        load_cz(1'b1, 1'b1);
        INSTR_BOUND = 1;
        tick();
        INSTR_BOUND = 0;
        chk("nest_full_held", INT_TAKE, 1'b0);
        RETI = 1;
        tick();
        RETI = 0;
        chk("nest_pop0_c", C_FLAG, pat[3][1]);
        chk("nest_pop0_z", Z_FLAG, pat[3][0]);
        INSTR_BOUND = 1;
        tick();
        INSTR_BOUND = 0; INT_REQ = 0;
        chk("nest_held_taken", INT_TAKE, 1'b1);
        tick();
        for (int k = 0; k < 4; k++) begin
            RETI = 1;
            tick();
            RETI = 0;
            chk("nest_lifo_c", C_FLAG, pop_exp[k][1]);
            chk("nest_lifo_z", Z_FLAG, pop_exp[k][0]);
            chk("nest_lifo_err", ERR, 1'b0);
        end
        chk("nest_i_after", I_FLAG, 1'b1);
`else
        // 6: single shadow, SEI inside ISR does not allow a second take
        I_SET = 1;
        tick();
        I_SET = 0;
        INT_REQ = 1; INSTR_BOUND = 1;
        tick();
        INSTR_BOUND = 0;
        chk("single_take", INT_TAKE, 1'b1);
        tick();
        I_SET = 1;
        tick();
        I_SET = 0;
        chk("single_sei_isr", I_FLAG, 1'b1);
        INSTR_BOUND = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("single_no_nest", INT_TAKE, 1'b0);
        end
        RETI = 1;
        tick();
        RETI = 0;
        chk("reti_beats_take", INT_TAKE, 1'b0);
        chk("reti_restore_c", C_FLAG, 1'b1);
        tick();
        chk("retake_after_reti", INT_TAKE, 1'b1);
        chk("retake_i_masked", I_FLAG, 1'b0);
`endif

        // reset in the middle of entry/ISR
        RST = 1;
        tick();
        RST = 0; INT_REQ = 0; INSTR_BOUND = 0;
        chk("midrst_take", INT_TAKE, 1'b0);
        chk("midrst_i", I_FLAG, 1'b0);
        chk("midrst_c", C_FLAG, 1'b0);
        RETI = 1;
        tick();
        RETI = 0;
        chk("midrst_depth0_err", ERR, 1'b1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
